// File: rtl/fifo_param.sv
// fifo_param: single-clock synchronous FIFO with occupancy count, threshold
// flags and synchronous flush.
//
// Optional feature: define FIFO_PARAM_ERRFLAG_EN to add the sticky error
// flags (overflow, underflow) and their clear input (clr_err).
//
// Parameters
//   WIDTH     data width in bits (>=1)
//   DEPTH     number of entries, power of two, >=2
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk           clock, all state updates on rising edge
//   rst           asynchronous active-low reset
//   in / we       write data / write request
//   out / re      registered read data (1-cycle latency) / read request
//   flush         synchronous discard of all contents, priority over we/re
//   count         current occupancy, 0..DEPTH
//   full, empty, almost_full, almost_empty   registered status flags
//   overflow, underflow, clr_err             sticky error flags (macro only)

module fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in,
    input  logic                     we,
    output logic                     full,
    output logic [WIDTH-1:0]         out,
    input  logic                     re,
    output logic                     empty,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty
`ifdef FIFO_PARAM_ERRFLAG_EN
    ,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt_c, rd_ptr_nxt_c;
    logic [CW-1:0]    count_nxt_c;
    logic             wr_en_c, rd_en_c;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign wr_en_c = we & (~full | re);
    assign rd_en_c = re & ~empty;

    // Next pointer / occupancy; flush overrides any read or write.
    always_comb begin
        wr_ptr_nxt_c = wr_ptr;
        rd_ptr_nxt_c = rd_ptr;
        count_nxt_c  = count;
        if (flush) begin
            wr_ptr_nxt_c = '0;
            rd_ptr_nxt_c = '0;
            count_nxt_c  = '0;
        end else begin
            if (wr_en_c) wr_ptr_nxt_c = wr_ptr + PW'(1);
            if (rd_en_c) rd_ptr_nxt_c = rd_ptr + PW'(1);
            if (wr_en_c && !rd_en_c)
                count_nxt_c = count + CW'(1);
            else if (!wr_en_c && rd_en_c)
                count_nxt_c = count - CW'(1);
        end
    end

    // Pointers, count and flags; flags are registered from the next count so
    // they always match the count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt_c;
            rd_ptr       <= rd_ptr_nxt_c;
            count        <= count_nxt_c;
            full         <= (count_nxt_c == CW'(DEPTH));
            empty        <= (count_nxt_c == '0);
            almost_full  <= (count_nxt_c >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt_c <= CW'(AE_LEVEL));
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c && !flush)
            mem[wr_ptr] <= in;
    end

    // Registered read data, holds when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out <= '0;
        else if (rd_en_c && !flush)
            out <= mem[rd_ptr];
    end

`ifdef FIFO_PARAM_ERRFLAG_EN
    logic ovf_set_c, unf_set_c;

    // A flushed cycle performs no transfer, so it raises no error.
    assign ovf_set_c = ~flush & we & full & ~re;
    assign unf_set_c = ~flush & re & empty;

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | ovf_set_c;
            underflow <= (underflow & ~clr_err) | unf_set_c;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scenarios followed by random traffic, every cycle
// compared against a queue-based reference model of the FIFO.

module tb_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             we, re, flush;
    logic [WIDTH-1:0] din, dout;
    logic             full, empty, af, ae;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_out;

    fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(din),
        .we(we),
        .full(full),
        .out(dout),
        .re(re),
        .empty(empty),
        .flush(flush),
        .count(count),
        .almost_full(af),
        .almost_empty(ae)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"}, 32'(count), 32'(n));
        chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ":full"},  32'(full),  32'(n == int'(DEPTH)));
        chk({tag, ":af"},    32'(af),    32'(n >= int'(AF)));
        chk({tag, ":ae"},    32'(ae),    32'(n <= int'(AE)));
        chk({tag, ":out"},   32'(dout),  32'(exp_out));
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic f, input logic [WIDTH-1:0] d);
        bit wr, rd;
        we = w; re = r; flush = f; din = d;
        if (f) begin
            q.delete();
        end else begin
            rd = r && (q.size() != 0);
            wr = w && ((q.size() < int'(DEPTH)) || r);
            if (rd) exp_out = q.pop_front();
            if (wr) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; flush = 1'b0; din = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        exp_out = '0;
        #25;
        check_all("reset");
        #5;
        rst = 1'b1;

        // Three writes then three reads.
        step("w5", 1'b1, 1'b0, 1'b0, 8'd5);
        step("w6", 1'b1, 1'b0, 1'b0, 8'd6);
        step("w7", 1'b1, 1'b0, 1'b0, 8'd7);
        for (int i = 0; i < 3; i++) step("r567", 1'b0, 1'b1, 1'b0, 8'd0);

        // Overfill: 9 writes, the last one dropped, then drain.
        for (int v = 8; v <= 16; v++) step("fill9", 1'b1, 1'b0, 1'b0, 8'(v));
        for (int i = 0; i < 8; i++) step("drain8", 1'b0, 1'b1, 1'b0, 8'd0);

        // Read from empty is ignored.
        step("rd_empty", 1'b0, 1'b1, 1'b0, 8'd0);
        step("rd_empty_wr", 1'b1, 1'b1, 1'b0, 8'h3C);
        step("rd_3c", 1'b0, 1'b1, 1'b0, 8'd0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) step("fill_full", 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        step("full_rw", 1'b1, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 8; i++) step("drain_aa", 1'b0, 1'b1, 1'b0, 8'd0);

        // Flush beats a concurrent write; new data afterwards.
        for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        step("flush_we", 1'b1, 1'b0, 1'b1, 8'h55);
        step("post_flush_w", 1'b1, 1'b0, 1'b0, 8'h66);
        step("post_flush_r", 1'b0, 1'b1, 1'b0, 8'd0);

        // Streaming through wrap with three entries resident.
        for (int i = 0; i < 3; i++) step("pre3", 1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 3; i++) step("post3", 1'b0, 1'b1, 1'b0, 8'd0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
        step("pre_rst_rd", 1'b0, 1'b1, 1'b0, 8'd0);
        idle_inputs();
        rst = 1'b0;
        #2;
        q.delete();
        exp_out = '0;
        check_all("mid_rst");
        #4;
        rst = 1'b1;
        step("after_rst_w", 1'b1, 1'b0, 1'b0, 8'hC3);
        step("after_rst_r", 1'b0, 1'b1, 1'b0, 8'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic w, r, f;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 31) == 0);
            step("rand", w, r, f, 8'($urandom));
        end

        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
